// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence front end.
package geofence_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned NPTS     = 7;
  localparam int unsigned CORE_LAT = 23;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT
  } gf_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/geofence_set_buf.sv
// Two-bank ping-pong store for 7-point coordinate sets.
// Writes fill one bank at a time; the reader frees a bank once it has
// streamed its last point.
module geofence_set_buf
  import geofence_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  point_t           wr_data,
  output logic [1:0]       bank_full,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output point_t           rd_data,
  input  logic             free_valid,
  input  logic             free_bank
);

  point_t           mem [2][NPTS];
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             rdy_en;
  logic             wr_fire;
  logic             fill_done;
  logic [1:0]       full_nxt;

  assign wr_ready  = rdy_en & ~bank_full[wr_bank];
  assign wr_fire   = wr_valid & wr_ready;
  assign fill_done = wr_fire && (wr_idx == IDX_W'(NPTS - 1));
  assign rd_data   = mem[rd_bank][rd_idx];

  // Full-flag update: a fill and a free only ever target different banks.
  always_comb begin
    full_nxt = bank_full;
    if (free_valid) full_nxt[free_bank] = 1'b0;
    if (fill_done)  full_nxt[wr_bank]   = 1'b1;
  end

  // Point storage; contents need no reset because the full flags gate use.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_idx] <= wr_data;
  end

  // Write pointer, bank flags and post-reset ready enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      bank_full <= '0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      bank_full <= full_nxt;
      if (wr_fire) begin
        if (fill_done) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/geofence_driver.sv
// Front end for the geofence core: buffers 7-point sets, streams each one
// into the core's LOAD window, and reports one result (or a watchdog abort)
// per set. The core is held in reset whenever no complete set is pending.
module geofence_driver
  import geofence_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned ID_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               gf_reset,
  output logic [COORD_W-1:0] gf_x,
  output logic [COORD_W-1:0] gf_y,
  input  logic               gf_valid,
  input  logic               gf_is_inside,
  output logic               res_valid,
  output logic               res_inside,
  output logic               res_timeout,
  output logic [ID_W-1:0]    res_id
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  gf_state_e          state;
  logic               rd_bank;
  logic [IDX_W-1:0]   k;
  logic [IDX_W-1:0]   rd_idx;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [ID_W-1:0]    id_cnt;
  logic [1:0]         bank_full;
  point_t             in_pt;
  point_t             rd_data;
  logic               free_valid;
  logic               last_pt;

  assign in_pt.x    = in_x;
  assign in_pt.y    = in_y;
  assign last_pt    = (k == IDX_W'(NPTS - 1));
  assign free_valid = (state == STREAM) && last_pt;

  // Read address runs one entry ahead of k so gf_x/gf_y register entry k
  // on the edge that opens the k-th STREAM cycle.
  assign rd_idx = (state == STREAM && !last_pt) ? k + IDX_W'(1) : '0;

  geofence_set_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (in_valid),
    .wr_ready   (in_ready),
    .wr_data    (in_pt),
    .bank_full  (bank_full),
    .rd_bank    (rd_bank),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .free_valid (free_valid),
    .free_bank  (rd_bank)
  );

  // Sequencer: IDLE holds the core in reset, STREAM feeds 7 points, WAIT
  // collects the result or aborts after TIMEOUT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      k           <= '0;
      wait_cnt    <= '0;
      id_cnt      <= '0;
      gf_reset    <= 1'b1;
      gf_x        <= '0;
      gf_y        <= '0;
      res_valid   <= 1'b0;
      res_inside  <= 1'b0;
      res_timeout <= 1'b0;
      res_id      <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          gf_reset <= 1'b1;
          if (bank_full[rd_bank]) begin
            state    <= STREAM;
            gf_reset <= 1'b0;
            k        <= '0;
            gf_x     <= rd_data.x;
            gf_y     <= rd_data.y;
          end
        end
        STREAM: begin
          if (last_pt) begin
            state    <= WAIT;
            rd_bank  <= ~rd_bank;
            wait_cnt <= '0;
          end else begin
            k    <= k + IDX_W'(1);
            gf_x <= rd_data.x;
            gf_y <= rd_data.y;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WCNT_W'(1);
          if (gf_valid) begin
            res_valid   <= 1'b1;
            res_inside  <= gf_is_inside;
            res_timeout <= 1'b0;
            res_id      <= id_cnt;
            id_cnt      <= id_cnt + ID_W'(1);
            // Keeping gf_reset low lets the core roll straight into its next
            // LOAD window when another set is already waiting.
            if (bank_full[rd_bank]) begin
              state <= STREAM;
              k     <= '0;
              gf_x  <= rd_data.x;
              gf_y  <= rd_data.y;
            end else begin
              state    <= IDLE;
              gf_reset <= 1'b1;
            end
          end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
            res_valid   <= 1'b1;
            res_inside  <= 1'b0;
            res_timeout <= 1'b1;
            res_id      <= id_cnt;
            id_cnt      <= id_cnt + ID_W'(1);
            state       <= IDLE;
            gf_reset    <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          gf_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_driver.sv
// Bench for geofence_driver: a stand-in geofence core plus a timeline model
// that predicts every set's stream window and result cycle.
`timescale 1ns/1ps
module tb_geofence_driver;
  import geofence_pkg::*;

  localparam int unsigned T   = 32;
  localparam int unsigned IDW = 8;
  localparam int          MAXS = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [9:0]     in_x, in_y, gf_x, gf_y;
  logic           gf_reset, gf_valid, gf_is_inside;
  logic           res_valid, res_inside, res_timeout;
  logic [IDW-1:0] res_id;

  geofence_driver #(.TIMEOUT(T), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .gf_reset(gf_reset), .gf_x(gf_x), .gf_y(gf_y),
    .gf_valid(gf_valid), .gf_is_inside(gf_is_inside), .res_valid(res_valid),
    .res_inside(res_inside), .res_timeout(res_timeout), .res_id(res_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  // model state
  int src_x[$], src_y[$];
  int acc_x[$], acc_y[$];
  int n_sets, n_freed;
  int start_c[MAXS], res_c[MAXS], chk_c[MAXS];
  bit to_f[MAXS], in_f[MAXS];
  int vprob;
  bit tie0, noise;
  // stand-in core
  int ccnt;
  int cpx[7], cpy[7];
  // observations for hand-computed checks
  int obs_fall, obs_res_cyc, obs_res_in, obs_res_to, obs_res_id, obs_rst_at_res;
  int obs_ready_low, obs_res_cnt, acc7_cyc;
  int res_hist[$];
  logic prev_gfr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strict interior test for a convex fence listed in order; point 0 is the object.
  function automatic bit inside_poly(input int px[7], input int py[7]);
    int pos, neg, j, cr;
    pos = 0; neg = 0;
    for (int i = 1; i <= 6; i++) begin
      j  = (i == 6) ? 1 : i + 1;
      cr = (px[j] - px[i]) * (py[0] - py[i]) - (py[j] - py[i]) * (px[0] - px[i]);
      if (cr > 0) pos++;
      else if (cr < 0) neg++;
    end
    return (pos == 6) || (neg == 6);
  endfunction

  task automatic queue_set(input int ox, input int oy);
    int fx[6] = '{0, 3, 8, 10, 8, 3};
    int fy[6] = '{5, 0, 0, 5, 10, 10};
    src_x.push_back(ox); src_y.push_back(oy);
    for (int i = 0; i < 6; i++) begin
      src_x.push_back(fx[i]); src_y.push_back(fy[i]);
    end
  endtask

  task automatic model_reset();
    cyc = 0; n_sets = 0; n_freed = 0; ccnt = 0; prev_gfr = 1'b1;
    acc_x.delete(); acc_y.delete(); src_x.delete(); src_y.delete();
    obs_ready_low = 0; obs_res_cnt = 0; res_hist.delete();
  endtask

  // One clock cycle: stand-in core, compare against model, drive inputs.
  task automatic step();
    bit exp_ready, exp_gfr, exp_rv, acc;
    int rset, eidx, n, prev_chk, avail;
    int ax[7], ay[7];
    @(negedge clk);
    // geofence core stand-in: 7 load cycles, result strobe 22 cycles later
    if (gf_reset) begin
      ccnt = 0;
      gf_valid = noise ? 1'($urandom_range(1)) : 1'b0;
      gf_is_inside = 1'($urandom_range(1));
    end else begin
      gf_valid = 1'b0;
      if (ccnt < 7) begin cpx[ccnt] = int'(gf_x); cpy[ccnt] = int'(gf_y); end
      if (ccnt == 22) begin
        gf_valid = !tie0;
        gf_is_inside = inside_poly(cpx, cpy);
      end
      ccnt = (ccnt == 22) ? 0 : ccnt + 1;
    end
    // expected outputs for this cycle
    while (n_freed < n_sets && start_c[n_freed] + 7 <= cyc) n_freed++;
    exp_ready = (n_sets - n_freed) < 2;
    exp_gfr = 1'b1; exp_rv = 1'b0; rset = -1; eidx = -1;
    for (int i = 0; i < n_sets; i++) begin
      if (cyc >= start_c[i] && cyc < res_c[i]) exp_gfr = 1'b0;
      if (cyc == res_c[i]) begin exp_rv = 1'b1; rset = i; end
      if (cyc >= start_c[i] && cyc < start_c[i] + 7) eidx = 7 * i + (cyc - start_c[i]);
    end
    chk("in_ready", int'(in_ready), int'(exp_ready));
    chk("gf_reset", int'(gf_reset), int'(exp_gfr));
    chk("res_valid", int'(res_valid), int'(exp_rv));
    if (rset >= 0) begin
      chk("res_inside", int'(res_inside), to_f[rset] ? 0 : int'(in_f[rset]));
      chk("res_timeout", int'(res_timeout), int'(to_f[rset]));
      chk("res_id", int'(res_id), rset % (1 << IDW));
    end
    if (eidx >= 0) begin
      chk("gf_x", int'(gf_x), acc_x[eidx]);
      chk("gf_y", int'(gf_y), acc_y[eidx]);
    end
    // observations
    if (prev_gfr && !gf_reset) obs_fall = cyc;
    prev_gfr = gf_reset;
    if (!in_ready) obs_ready_low++;
    if (res_valid) begin
      obs_res_cyc = cyc; obs_res_in = int'(res_inside); obs_res_to = int'(res_timeout);
      obs_res_id = int'(res_id); obs_rst_at_res = int'(gf_reset); obs_res_cnt++;
      res_hist.push_back(cyc);
    end
    // upstream driver: hold each point until the model says it was taken
    if (src_x.size() > 0) begin
      in_valid = ($urandom_range(99) < vprob);
      in_x = 10'(src_x[0]); in_y = 10'(src_y[0]);
    end else begin
      in_valid = 1'b0; in_x = 10'($urandom); in_y = 10'($urandom);
    end
    acc = in_valid && exp_ready;
    if (acc) begin
      acc_x.push_back(src_x.pop_front());
      acc_y.push_back(src_y.pop_front());
      if (acc_x.size() % 7 == 0) begin
        n = n_sets;
        avail = cyc + 1;
        prev_chk = (n == 0) ? 0 : chk_c[n - 1];
        start_c[n] = ((prev_chk > avail) ? prev_chk : avail) + 1;
        to_f[n] = tie0;
        res_c[n] = tie0 ? start_c[n] + 7 + T : start_c[n] + CORE_LAT;
        chk_c[n] = tie0 ? start_c[n] + 7 + T : start_c[n] + CORE_LAT - 1;
        for (int i = 0; i < 7; i++) begin ax[i] = acc_x[7*n + i]; ay[i] = acc_y[7*n + i]; end
        in_f[n] = inside_poly(ax, ay);
        n_sets++;
        acc7_cyc = cyc;
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input int budget);
    int b;
    b = 0;
    while ((src_x.size() > 0 || (n_sets > 0 && cyc <= res_c[n_sets - 1])) && b < budget) begin
      step();
      b++;
    end
    if (b >= budget) begin
      n_checks++; n_fail++;
      $display("FAIL run_budget: got %0d cycles expected fewer than %0d", b, budget);
    end
  endtask

  // Called right after a negedge; reset is released on a later negedge.
  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; gf_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    gf_valid = 1'b0; gf_is_inside = 1'b0;
    vprob = 100; tie0 = 1'b0; noise = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_gf_reset", int'(gf_reset), 1);
    chk("rst_gf_x", int'(gf_x), 0);
    chk("rst_gf_y", int'(gf_y), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_inside", int'(res_inside), 0);
    chk("rst_res_timeout", int'(res_timeout), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();

    // object inside the hexagon
    queue_set(5, 5);
    run_until_done(200);
    chk("t1_fall_after_accept", obs_fall - acc7_cyc, 2);
    chk("t1_latency", obs_res_cyc - obs_fall, 23);
    chk("t1_inside", obs_res_in, 1);
    chk("t1_id", obs_res_id, 0);

    // object far outside
    queue_set(20, 20);
    run_until_done(200);
    chk("t2_inside", obs_res_in, 0);
    chk("t2_timeout", obs_res_to, 0);
    chk("t2_id", obs_res_id, 1);

    // two sets back to back
    do_reset();
    queue_set(5, 5);
    queue_set(9, 9);
    run_until_done(300);
    chk("t3_ready_low_cycles", obs_ready_low, 1);
    chk("t3_results", obs_res_cnt, 2);
    if (res_hist.size() == 2) chk("t3_restream_gap", res_hist[1] - res_hist[0], 23);
    chk("t3_last_id", obs_res_id, 1);

    // core never answers
    tie0 = 1'b1;
    queue_set(5, 5);
    run_until_done(300);
    tie0 = 1'b0;
    chk("t4_timeout", obs_res_to, 1);
    chk("t4_inside", obs_res_in, 0);
    chk("t4_abort_cycle", obs_res_cyc - obs_fall, 7 + T);
    chk("t4_gf_reset_after", obs_rst_at_res, 1);

    // reset in the middle of a stream (k = 3)
    queue_set(5, 5);
    begin : t5_wait
      int b;
      b = 0;
      while (!(n_sets > 0 && cyc == start_c[n_sets - 1] + 4) && b < 200) begin
        step(); b++;
      end
      chk("t5_reached_k3", int'(n_sets > 0 && cyc == start_c[n_sets - 1] + 4), 1);
    end
    reset = 1'b0;
    #1;
    chk("t5_gf_reset", int'(gf_reset), 1);
    chk("t5_res_valid", int'(res_valid), 0);
    chk("t5_in_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    queue_set(6, 4);
    run_until_done(200);
    chk("t5_id_after_reset", obs_res_id, 0);
    chk("t5_results", obs_res_cnt, 1);

    // random traffic with spurious strobes while the core is held in reset
    noise = 1'b1;
    for (int batch = 0; batch < 3; batch++) begin
      vprob = int'($urandom_range(20, 100));
      for (int s = 0; s < 15; s++) begin
        if ($urandom_range(3) == 0) queue_set(int'($urandom_range(15, 40)), int'($urandom_range(0, 40)));
        else queue_set(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      end
      run_until_done(4000);
    end
    chk("t6_results", obs_res_cnt, 46);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog: got no finish expected finish before %0d ns", 1000000);
    $fatal(1);
  end

endmodule
